uart_rx_deserializer: RTL

Receive-side serial stage of the uart_16550_rll core. It oversamples the synchronized `rxd` line at 16× the baud rate and frames each character according to the line-control settings. It checks parity and stop bits and detects break. Each received character is delivered as a single-cycle push, with error flags, to the RX FIFO directly downstream.

---
 rtl/uart_rx_deserializer_if.sv | 26 ++
 rtl/uart_rx_deserializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer_if.sv
// Signal bundle between the UART line/LCR side and the RX deserializer.
// The master drives the serial line, baud tick and line control; the slave returns received characters.
interface uart_rx_deserializer_if;
    logic       baud_en;
    logic       rxd;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic [7:0] rx_data;
    logic       rx_push;
    logic       rx_pe;
    logic       rx_fe;
    logic       rx_bi;
    logic       rx_busy;

    modport master (
        output baud_en, rxd, wls, pen, eps, sp,
        input  rx_data, rx_push, rx_pe, rx_fe, rx_bi, rx_busy
    );

    modport slave (
        input  baud_en, rxd, wls, pen, eps, sp,
        output rx_data, rx_push, rx_pe, rx_fe, rx_bi, rx_busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 16x-oversampling UART receive framer: start/data/parity/stop sampling at mid-bit,
// parity, framing and break detection, one-cycle push of each character to the RX FIFO.
module uart_rx_deserializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_rx_deserializer_if.slave   bus
);

    localparam logic [3:0] LP_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LP_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    state_t     r_state,      w_state;
    logic       r_rxd_meta;
    logic       r_rxs;
    logic [3:0] r_sample_cnt, w_sample_cnt;
    logic [2:0] r_bit_cnt,    w_bit_cnt;
    logic [7:0] r_shift,      w_shift;
    logic       r_par_acc,    w_par_acc;
    logic       r_all_zero,   w_all_zero;
    logic       r_pe_acc,     w_pe_acc;
    logic [1:0] r_wls,        w_wls;
    logic       r_pen,        w_pen;
    logic       r_eps,        w_eps;
    logic       r_sp,         w_sp;
    logic [7:0] r_rx_data,    w_rx_data;
    logic       r_rx_push,    w_rx_push;
    logic       r_rx_pe,      w_rx_pe;
    logic       r_rx_fe,      w_rx_fe;
    logic       r_rx_bi,      w_rx_bi;

    logic       w_tick;
    logic       w_exp_par;
    logic       w_mid_bit;

    assign w_tick    = bus.baud_en;
    assign w_mid_bit = w_tick && (r_sample_cnt == LP_LAST);
    // Even parity expects the XOR of the data; stick parity forces the bit to ~eps.
    assign w_exp_par = r_sp ? ~r_eps : (r_eps ? r_par_acc : ~r_par_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta   <= 1'b1;
            r_rxs        <= 1'b1;
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_all_zero   <= 1'b0;
            r_pe_acc     <= 1'b0;
            r_wls        <= '0;
            r_pen        <= 1'b0;
            r_eps        <= 1'b0;
            r_sp         <= 1'b0;
            r_rx_data    <= '0;
            r_rx_push    <= 1'b0;
            r_rx_pe      <= 1'b0;
            r_rx_fe      <= 1'b0;
            r_rx_bi      <= 1'b0;
        end else begin
            r_rxd_meta   <= bus.rxd;
            r_rxs        <= r_rxd_meta;
            r_state      <= w_state;
            r_sample_cnt <= w_sample_cnt;
            r_bit_cnt    <= w_bit_cnt;
            r_shift      <= w_shift;
            r_par_acc    <= w_par_acc;
            r_all_zero   <= w_all_zero;
            r_pe_acc     <= w_pe_acc;
            r_wls        <= w_wls;
            r_pen        <= w_pen;
            r_eps        <= w_eps;
            r_sp         <= w_sp;
            r_rx_data    <= w_rx_data;
            r_rx_push    <= w_rx_push;
            r_rx_pe      <= w_rx_pe;
            r_rx_fe      <= w_rx_fe;
            r_rx_bi      <= w_rx_bi;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_sample_cnt = r_sample_cnt;
        w_bit_cnt    = r_bit_cnt;
        w_shift      = r_shift;
        w_par_acc    = r_par_acc;
        w_all_zero   = r_all_zero;
        w_pe_acc     = r_pe_acc;
        w_wls        = r_wls;
        w_pen        = r_pen;
        w_eps        = r_eps;
        w_sp         = r_sp;
        w_rx_data    = r_rx_data;
        w_rx_push    = 1'b0;
        w_rx_pe      = r_rx_pe;
        w_rx_fe      = r_rx_fe;
        w_rx_bi      = r_rx_bi;

        if (w_tick && (r_state != S_IDLE)) begin
            w_sample_cnt = r_sample_cnt + 4'd1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_tick && !r_rxs) begin
                    w_state      = S_START;
                    w_sample_cnt = '0;
                    w_bit_cnt    = '0;
                    w_shift      = '0;
                    w_par_acc    = 1'b0;
                    w_all_zero   = 1'b1;
                    w_pe_acc     = 1'b0;
                    w_wls        = bus.wls;
                    w_pen        = bus.pen;
                    w_eps        = bus.eps;
                    w_sp         = bus.sp;
                end
            end
            S_START: begin
                if (w_tick && (r_sample_cnt == LP_MID)) begin
                    if (r_rxs) begin
                        w_state = S_IDLE;
                    end else begin
                        w_state      = S_DATA;
                        w_sample_cnt = '0;
                        w_bit_cnt    = '0;
                    end
                end
            end
            S_DATA: begin
                if (w_mid_bit) begin
                    w_shift[r_bit_cnt] = r_rxs;
                    w_par_acc          = r_par_acc ^ r_rxs;
                    if (r_rxs) begin
                        w_all_zero = 1'b0;
                    end
                    // Last data bit index is wls+4.
                    if ({1'b1, r_wls} == r_bit_cnt) begin
                        w_state = r_pen ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_cnt = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_mid_bit) begin
                    w_pe_acc = (r_rxs != w_exp_par);
                    if (r_rxs) begin
                        w_all_zero = 1'b0;
                    end
                    w_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_mid_bit) begin
                    w_rx_push = 1'b1;
                    w_rx_pe   = r_pe_acc;
                    w_rx_fe   = ~r_rxs;
                    w_rx_bi   = r_all_zero & ~r_rxs;
                    w_rx_data = (r_all_zero & ~r_rxs) ? 8'h00 : r_shift;
                    w_state   = r_rxs ? S_IDLE : S_BRK_WAIT;
                end
            end
            S_BRK_WAIT: begin
                if (w_tick && r_rxs) begin
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.rx_data = r_rx_data;
    assign bus.rx_push = r_rx_push;
    assign bus.rx_pe   = r_rx_pe;
    assign bus.rx_fe   = r_rx_fe;
    assign bus.rx_bi   = r_rx_bi;
    assign bus.rx_busy = (r_state != S_IDLE);

endmodule
